// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - execute-stage issue sequencer with mul/div dispatch
//
// Purpose: accepts one decoded instruction per de_valid_i/de_ready_o handshake,
// runs single-cycle ops through the external combinational ALU and RV32M ops
// through an external iterative mul/div unit, then holds the result on the
// ex_valid_o/ex_ready_i interface. Handles flush and mul/div timeout.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   de_*                        decoded instruction in (valid/ready)
//   flush_i                     kill the in-flight instruction
//   alu_*_o / alu_wdata_i       latched issue fields out, ALU result in
//   md_start_o / md_abort_o     one-cycle pulses to the mul/div unit
//   md_op_o, md_a_o, md_b_o     mul/div funct3 and operands
//   md_done_i, md_result_i      mul/div completion pulse and result
//   ex_*                        result out to writeback (valid/ready)
//
// Optional feature: define MULDIV_EN to sequence M ops through the mul/div
// unit. Without it M ops complete through the ALU path flagged with ex_err_o.
module ex_issue_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_valid_i,
  output logic        de_ready_o,
  input  logic [31:0] de_inst_i,
  input  logic [31:0] de_pc_i,
  input  logic [31:0] de_op1_i,
  input  logic [31:0] de_op2_i,
  input  logic        de_rd_en_i,
  input  logic [4:0]  de_rd_addr_i,
  input  logic        flush_i,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  output logic [31:0] alu_inst_o,
  output logic [31:0] alu_pc_o,
  output logic        alu_rd_reg_en_o,
  output logic [4:0]  alu_rd_reg_addr_o,
  input  logic [31:0] alu_wdata_i,
  output logic        md_start_o,
  output logic        md_abort_o,
  output logic [2:0]  md_op_o,
  output logic [31:0] md_a_o,
  output logic [31:0] md_b_o,
  input  logic        md_done_i,
  input  logic [31:0] md_result_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_wdata_o,
  output logic        ex_rd_en_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_inst_o,
  output logic        ex_err_o
);

  typedef enum logic [2:0] {IDLE, ALU, MD_START, MD_WAIT, OUT} state_t;

  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  state_t      state;
  logic        accept;
  logic        de_to_md;
  logic        alu_is_m;
  logic        rd_nz;
  logic [31:0] alu_res;
  logic        alu_err;

  assign de_ready_o = (state == IDLE) || ((state == OUT) && ex_ready_i);
  assign accept     = de_valid_i && de_ready_o && !flush_i;
  assign alu_is_m   = (alu_inst_o[6:0] == OPC_OP) && (alu_inst_o[31:25] == F7_MUL);
  // Writes to x0 are never reported as enabled.
  assign rd_nz      = alu_rd_reg_en_o && (alu_rd_reg_addr_o != 5'd0);

`ifdef MULDIV_EN
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MD_TIMEOUT);
  logic [CNT_W-1:0] cnt;

  // Divide/remainder by zero has a fixed architectural result, so it is
  // resolved on the ALU path and never occupies the mul/div unit.
  assign de_to_md = (de_inst_i[6:0] == OPC_OP) && (de_inst_i[31:25] == F7_MUL)
                    && !(de_inst_i[14] && (de_op2_i == 32'd0));
`else
  logic unused_md;
  assign unused_md  = md_done_i ^ (^md_result_i) ^ (MD_TIMEOUT > 0) ^ (CNT_W > 0);
  assign de_to_md   = 1'b0;
  assign md_start_o = 1'b0;
  assign md_abort_o = 1'b0;
  assign md_op_o    = 3'd0;
  assign md_a_o     = 32'd0;
  assign md_b_o     = 32'd0;
`endif

  // An M op reaching the ALU state is either a divide-by-zero bypass or,
  // without the mul/div unit, an unsupported op.
  always_comb begin
    alu_res = alu_wdata_i;
    alu_err = 1'b0;
    if (alu_is_m) begin
`ifdef MULDIV_EN
      alu_res = alu_inst_o[13] ? alu_op1_o : 32'hFFFF_FFFF;
`else
      alu_res = 32'd0;
      alu_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      alu_op1_o         <= 32'd0;
      alu_op2_o         <= 32'd0;
      alu_inst_o        <= 32'd0;
      alu_pc_o          <= 32'd0;
      alu_rd_reg_en_o   <= 1'b0;
      alu_rd_reg_addr_o <= 5'd0;
      ex_valid_o        <= 1'b0;
      ex_wdata_o        <= 32'd0;
      ex_rd_en_o        <= 1'b0;
      ex_rd_addr_o      <= 5'd0;
      ex_pc_o           <= 32'd0;
      ex_inst_o         <= 32'd0;
      ex_err_o          <= 1'b0;
`ifdef MULDIV_EN
      cnt               <= '0;
      md_start_o        <= 1'b0;
      md_abort_o        <= 1'b0;
      md_op_o           <= 3'd0;
      md_a_o            <= 32'd0;
      md_b_o            <= 32'd0;
`endif
    end else begin
`ifdef MULDIV_EN
      md_start_o <= 1'b0;
      md_abort_o <= 1'b0;
`endif
      if (accept) begin
        alu_op1_o         <= de_op1_i;
        alu_op2_o         <= de_op2_i;
        alu_inst_o        <= de_inst_i;
        alu_pc_o          <= de_pc_i;
        alu_rd_reg_en_o   <= de_rd_en_i;
        alu_rd_reg_addr_o <= de_rd_addr_i;
`ifdef MULDIV_EN
        if (de_to_md) begin
          md_a_o     <= de_op1_i;
          md_b_o     <= de_op2_i;
          md_op_o    <= de_inst_i[14:12];
          md_start_o <= 1'b1;
        end
`endif
      end

      if (flush_i) begin
        state      <= IDLE;
        ex_valid_o <= 1'b0;
`ifdef MULDIV_EN
        if ((state == MD_START) || (state == MD_WAIT)) md_abort_o <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (accept) state <= de_to_md ? MD_START : ALU;
          end
          ALU: begin
            ex_wdata_o   <= alu_res;
            ex_err_o     <= alu_err;
            ex_rd_en_o   <= rd_nz && !alu_err;
            ex_rd_addr_o <= alu_rd_reg_addr_o;
            ex_pc_o      <= alu_pc_o;
            ex_inst_o    <= alu_inst_o;
            ex_valid_o   <= 1'b1;
            state        <= OUT;
          end
`ifdef MULDIV_EN
          MD_START: begin
            cnt   <= '0;
            state <= MD_WAIT;
          end
          MD_WAIT: begin
            // A completion arriving in the timeout cycle still wins.
            if (md_done_i || (cnt == TMO)) begin
              ex_wdata_o   <= md_done_i ? md_result_i : 32'd0;
              ex_err_o     <= !md_done_i;
              ex_rd_en_o   <= md_done_i && rd_nz;
              ex_rd_addr_o <= alu_rd_reg_addr_o;
              ex_pc_o      <= alu_pc_o;
              ex_inst_o    <= alu_inst_o;
              ex_valid_o   <= 1'b1;
              md_abort_o   <= !md_done_i;
              state        <= OUT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`endif
          OUT: begin
            if (ex_ready_i) begin
              ex_valid_o <= 1'b0;
              if (accept) state <= de_to_md ? MD_START : ALU;
              else        state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb/tb_ex_issue_ctrl.sv - self-checking bench for ex_issue_ctrl
module tb_ex_issue_ctrl;

  localparam int MDT = 16;
  localparam int CW  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_valid = 1'b0;
  logic        de_ready_o;
  logic [31:0] de_inst = 32'd0;
  logic [31:0] de_pc = 32'd0;
  logic [31:0] de_op1 = 32'd0;
  logic [31:0] de_op2 = 32'd0;
  logic        de_rd_en = 1'b0;
  logic [4:0]  de_rd_addr = 5'd0;
  logic        flush = 1'b0;
  logic [31:0] alu_op1_o, alu_op2_o, alu_inst_o, alu_pc_o;
  logic        alu_rd_reg_en_o;
  logic [4:0]  alu_rd_reg_addr_o;
  logic [31:0] alu_wdata;
  logic        md_start_o, md_abort_o;
  logic [2:0]  md_op_o;
  logic [31:0] md_a_o, md_b_o;
  logic        md_done = 1'b0;
  logic [31:0] md_result;
  logic        ex_valid_o;
  logic        ex_ready = 1'b0;
  logic [31:0] ex_wdata_o;
  logic        ex_rd_en_o;
  logic [4:0]  ex_rd_addr_o;
  logic [31:0] ex_pc_o, ex_inst_o;
  logic        ex_err_o;

  int checks = 0;
  int failures = 0;
  int starts_seen = 0;
  int exp_starts = 0;

  always #5 clk = ~clk;

  // Reference RV32M arithmetic; also serves as the mul/div unit model.
  function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    md_ref = 32'd0;
    case (f)
      3'd0: begin p = za * zb; md_ref = p[31:0]; end
      3'd1: begin p = sa * sb; md_ref = p[63:32]; end
      3'd2: begin p = sa * zb; md_ref = p[63:32]; end
      3'd3: begin p = za * zb; md_ref = p[63:32]; end
      3'd4: if (b == 0) md_ref = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) md_ref = a;
            else md_ref = $signed(a) / $signed(b);
      3'd5: md_ref = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) md_ref = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) md_ref = 32'd0;
            else md_ref = $signed(a) % $signed(b);
      default: md_ref = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    alu_ref = (inst[14:12] == 3'b110) ? (a | b) : (a + b);
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    mk_r = {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  assign alu_wdata = alu_ref(alu_inst_o, alu_op1_o, alu_op2_o);
  assign md_result = md_done ? md_ref(md_op_o, md_a_o, md_b_o) : 32'hDEAD_BEEF;

  always @(negedge clk) if (md_start_o) starts_seen++;

  ex_issue_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .de_valid_i(de_valid), .de_ready_o(de_ready_o),
    .de_inst_i(de_inst), .de_pc_i(de_pc), .de_op1_i(de_op1), .de_op2_i(de_op2),
    .de_rd_en_i(de_rd_en), .de_rd_addr_i(de_rd_addr), .flush_i(flush),
    .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_inst_o(alu_inst_o), .alu_pc_o(alu_pc_o),
    .alu_rd_reg_en_o(alu_rd_reg_en_o), .alu_rd_reg_addr_o(alu_rd_reg_addr_o), .alu_wdata_i(alu_wdata),
    .md_start_o(md_start_o), .md_abort_o(md_abort_o), .md_op_o(md_op_o),
    .md_a_o(md_a_o), .md_b_o(md_b_o), .md_done_i(md_done), .md_result_i(md_result),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready), .ex_wdata_o(ex_wdata_o),
    .ex_rd_en_o(ex_rd_en_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_pc_o(ex_pc_o),
    .ex_inst_o(ex_inst_o), .ex_err_o(ex_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT able to accept. md_delay is the MD_WAIT
  // cycle index in which md_done is pulsed (negative: never).
  task automatic run_op(input logic [31:0] inst, input logic [31:0] op1, input logic [31:0] op2,
                        input logic rd_en, input logic [4:0] rd, input int md_delay,
                        input int hold, input logic leave_ready);
    logic [31:0] pc, e_wdata;
    logic        e_err, e_md, e_tmo, e_rden, is_m;
    logic [2:0]  f3;
    int          k, exp_k;
    pc    = $urandom;
    f3    = inst[14:12];
    is_m  = (inst[6:0] == 7'b0110011) && (inst[31:25] == 7'b0000001);
    e_err = 1'b0;
    e_md  = 1'b0;
    e_tmo = 1'b0;
    e_wdata = alu_ref(inst, op1, op2);
    if (is_m) begin
`ifdef MULDIV_EN
      if (f3[2] && op2 == 32'd0) begin
        e_wdata = f3[1] ? op1 : 32'hFFFF_FFFF;
      end else begin
        e_md    = 1'b1;
        e_tmo   = (md_delay < 0) || (md_delay > MDT);
        e_err   = e_tmo;
        e_wdata = e_tmo ? 32'd0 : md_ref(f3, op1, op2);
      end
`else
      e_err   = 1'b1;
      e_wdata = 32'd0;
`endif
    end
    e_rden = rd_en && (rd != 5'd0) && !e_err;
    if (e_md) exp_starts++;

    de_valid = 1'b1; de_inst = inst; de_pc = pc; de_op1 = op1; de_op2 = op2;
    de_rd_en = rd_en; de_rd_addr = rd;
    #1;
    chk("accept_ready", 32'(de_ready_o), 1);
    @(negedge clk);
    de_valid = 1'b0;
    ex_ready = 1'b0;
    chk("issue_valid_low", 32'(ex_valid_o), 0);
    chk("alu_op1", alu_op1_o, op1);
    chk("alu_inst", alu_inst_o, inst);
    chk("alu_pc", alu_pc_o, pc);
    if (e_md) begin
      chk("md_start", 32'(md_start_o), 1);
      chk("md_a", md_a_o, op1);
      chk("md_b", md_b_o, op2);
      chk("md_op", 32'(md_op_o), 32'(f3));
      exp_k = e_tmo ? MDT + 1 : md_delay + 1;
      k = 0;
      while (k < MDT + 8) begin
        @(negedge clk);
        md_done = (k == md_delay);
        if (ex_valid_o) break;
        k++;
      end
      md_done = 1'b0;
      chk("md_latency", k, exp_k);
      chk("md_abort", 32'(md_abort_o), 32'(e_tmo));
    end else begin
      chk("no_md_start", 32'(md_start_o), 0);
      @(negedge clk);
    end
    chk("ex_valid", 32'(ex_valid_o), 1);
    chk("ex_wdata", ex_wdata_o, e_wdata);
    chk("ex_rd_en", 32'(ex_rd_en_o), 32'(e_rden));
    chk("ex_rd_addr", 32'(ex_rd_addr_o), 32'(rd));
    chk("ex_pc", ex_pc_o, pc);
    chk("ex_inst", ex_inst_o, inst);
    chk("ex_err", 32'(ex_err_o), 32'(e_err));
    chk("out_not_ready", 32'(de_ready_o), 0);
    chk("md_starts", starts_seen, exp_starts);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ex_valid_o), 1);
      chk("hold_wdata", ex_wdata_o, e_wdata);
      chk("hold_pc", ex_pc_o, pc);
      chk("hold_de_ready", 32'(de_ready_o), 0);
      chk("hold_abort_low", 32'(md_abort_o), 0);
    end
    ex_ready = 1'b1;
    #1;
    chk("handshake_ready", 32'(de_ready_o), 1);
    if (!leave_ready) begin
      @(negedge clk);
      ex_ready = 1'b0;
      chk("post_valid_low", 32'(ex_valid_o), 0);
      chk("post_idle_ready", 32'(de_ready_o), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ori, inst, op2;
    logic [2:0]  f3;
    int          sel, dly;
    ori = {12'h00F, 5'd1, 3'b110, 5'd5, 7'b0010011};

    repeat (3) @(negedge clk);
    chk("rst_de_ready", 32'(de_ready_o), 1);
    chk("rst_ex_valid", 32'(ex_valid_o), 0);
    chk("rst_md_start", 32'(md_start_o), 0);
    chk("rst_md_abort", 32'(md_abort_o), 0);
    chk("rst_ex_wdata", ex_wdata_o, 0);
    chk("rst_ex_err", 32'(ex_err_o), 0);
    chk("rst_alu_op1", alu_op1_o, 0);
    chk("rst_md_a", md_a_o, 0);
    rst = 1'b0;

    run_op(ori, 32'h0F0, 32'h00F, 1'b1, 5'd5, 0, 0, 1'b0);
    run_op(mk_r(7'h01, 3'b101), 32'd100, 32'd7, 1'b1, 5'd3, 9, 0, 1'b0);
    run_op(mk_r(7'h01, 3'b110), 32'h1234, 32'd0, 1'b1, 5'd4, 0, 0, 1'b0);
    run_op(mk_r(7'h01, 3'b100), 32'h55, 32'd0, 1'b1, 5'd6, 0, 0, 1'b0);
    run_op(mk_r(7'h01, 3'b100), 32'h99, 32'd3, 1'b1, 5'd7, -1, 0, 1'b0);
    run_op(mk_r(7'h01, 3'b101), 32'h99, 32'd3, 1'b1, 5'd7, MDT, 0, 1'b0);
    run_op(mk_r(7'h00, 3'b000), 32'd1, 32'd2, 1'b1, 5'd8, 0, 5, 1'b0);
    run_op(mk_r(7'h00, 3'b000), 32'd10, 32'd20, 1'b1, 5'd9, 0, 0, 1'b1);
    run_op(mk_r(7'h01, 3'b000), 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd10, 2, 0, 1'b1);
    run_op(ori, 32'h100, 32'h011, 1'b1, 5'd11, 0, 0, 1'b0);
    run_op(mk_r(7'h00, 3'b000), 32'd5, 32'd6, 1'b1, 5'd0, 0, 0, 1'b0);

    // flush while in the ALU state
    de_valid = 1'b1; de_inst = mk_r(7'h00, 3'b000); de_op1 = 32'h777; de_op2 = 32'd1;
    @(negedge clk);
    de_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_alu_valid", 32'(ex_valid_o), 0);
    chk("flush_alu_ready", 32'(de_ready_o), 1);
    @(negedge clk);
    chk("flush_alu_idle", 32'(ex_valid_o), 0);

    // flush blocks an accept in IDLE
    de_valid = 1'b1; de_inst = ori; de_op1 = 32'hABCD; flush = 1'b1;
    @(negedge clk);
    de_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept", alu_op1_o, 32'h777);
    repeat (2) @(negedge clk);
    chk("flush_no_accept_valid", 32'(ex_valid_o), 0);

    // flush overrides handshake and a same-cycle accept in OUT
    run_op(ori, 32'd1, 32'd2, 1'b1, 5'd12, 0, 0, 1'b1);
    flush = 1'b1; de_valid = 1'b1; de_inst = mk_r(7'h00, 3'b000); de_op1 = 32'h4444;
    @(negedge clk);
    flush = 1'b0; de_valid = 1'b0; ex_ready = 1'b0;
    chk("flush_out_valid", 32'(ex_valid_o), 0);
    chk("flush_out_ready", 32'(de_ready_o), 1);
    chk("flush_out_no_accept", alu_op1_o, 32'd1);
    @(negedge clk);
    chk("flush_out_idle", 32'(ex_valid_o), 0);

`ifdef MULDIV_EN
    // flush in MD_WAIT, then a stray completion
    de_valid = 1'b1; de_inst = mk_r(7'h01, 3'b101); de_op1 = 32'd1000; de_op2 = 32'd3;
    @(negedge clk);
    de_valid = 1'b0; exp_starts++;
    chk("flush_md_start", 32'(md_start_o), 1);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_md_abort", 32'(md_abort_o), 1);
    chk("flush_md_valid", 32'(ex_valid_o), 0);
    chk("flush_md_ready", 32'(de_ready_o), 1);
    md_done = 1'b1;
    @(negedge clk);
    md_done = 1'b0;
    chk("flush_md_abort_pulse", 32'(md_abort_o), 0);
    chk("late_done_valid", 32'(ex_valid_o), 0);
    @(negedge clk);
    chk("late_done_valid2", 32'(ex_valid_o), 0);
    chk("flush_md_starts", starts_seen, exp_starts);

    // reset mid-operation
    de_valid = 1'b1; de_inst = mk_r(7'h01, 3'b100); de_op1 = 32'd50; de_op2 = 32'd5;
    @(negedge clk);
    de_valid = 1'b0; exp_starts++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_abort", 32'(md_abort_o), 0);
    chk("rst_mid_valid", 32'(ex_valid_o), 0);
    chk("rst_mid_ready", 32'(de_ready_o), 1);
    chk("rst_mid_md_a", md_a_o, 0);
    chk("rst_mid_alu_op1", alu_op1_o, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      f3  = 3'($urandom);
      if (sel == 0)      inst = mk_r(7'h00, f3);
      else if (sel == 1) inst = {12'($urandom), 5'd1, f3, 5'd2, 7'b0010011};
      else               inst = mk_r(7'h01, f3);
      op2 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      dly = ($urandom_range(0, 9) == 0) ? MDT + 3 : $urandom_range(0, 12);
      run_op(inst, $urandom, op2, 1'($urandom), 5'($urandom), dly,
             $urandom_range(0, 3), (i < 39) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
